// File: rtl/morse_codec.sv
// Morse encoder (enc_* -> tone) and decoder (key -> dec_*) sharing one unit counter; mode is sampled in IDLE.
// Key path has 2 cycles of sync latency, plus DB_CYCLES more when MORSE_DEBOUNCE_EN is defined; enc_ready is low while busy.
module morse_codec #(
    parameter int UNIT      = 25000000,
    parameter int MAX_LEN   = 5,
    parameter int DB_CYCLES = 500000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic               enc_valid,
    output logic               enc_ready,
    input  logic [2:0]         enc_len,
    input  logic [MAX_LEN-1:0] enc_bits,
    output logic               tone,
    input  logic               key,
    output logic               dec_valid,
    output logic [2:0]         dec_len,
    output logic [MAX_LEN-1:0] dec_bits,
    output logic               dec_err,
    output logic               busy
);
    localparam int            CW   = $clog2(7*UNIT+1);
    localparam logic [CW-1:0] C1M  = CW'(UNIT-1);
    localparam logic [CW-1:0] C2   = CW'(2*UNIT);
    localparam logic [CW-1:0] C3M  = CW'(3*UNIT-1);
    localparam logic [CW-1:0] C7   = CW'(7*UNIT);
    localparam logic [CW-1:0] C7M  = CW'(7*UNIT-1);
    localparam logic [2:0]    LMAX = 3'(MAX_LEN);

    typedef enum logic [2:0] {IDLE, E_MARK, E_GAP, E_LGAP, D_PRESS, D_GAP} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [2:0]         len_q, len_d;
    logic [MAX_LEN-1:0] bits_q, bits_d;
    logic               err_q, err_d;
    logic               dv_q, dv_d;
    logic               de_q, de_d;
    logic [2:0]         dlen_q, dlen_d;
    logic [MAX_LEN-1:0] dbits_q, dbits_d;
    logic               ks1_q, ks2_q;
    logic               key_s;

`ifdef MORSE_DEBOUNCE_EN
    localparam int DBW = $clog2(DB_CYCLES+1);
    logic [DBW-1:0] db_cnt_q;
    logic           db_q;

    // Output follows the synchronised key only after it has disagreed for DB_CYCLES samples in a row.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt_q <= '0;
            db_q     <= 1'b0;
        end else if (ks2_q == db_q) begin
            db_cnt_q <= '0;
        end else if (db_cnt_q == DBW'(DB_CYCLES-1)) begin
            db_q     <= ks2_q;
            db_cnt_q <= '0;
        end else begin
            db_cnt_q <= db_cnt_q + DBW'(1);
        end
    end
    assign key_s = db_q;
`else
    assign key_s = ks2_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        len_d   = len_q;
        bits_d  = bits_q;
        err_d   = err_q;
        dv_d    = 1'b0;
        de_d    = 1'b0;
        dlen_d  = dlen_q;
        dbits_d = dbits_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (mode) begin
                    if (enc_valid && enc_len != 3'd0 && enc_len <= LMAX) begin
                        len_d   = enc_len;
                        bits_d  = enc_bits;
                        state_d = E_MARK;
                    end
                end else if (key_s) begin
                    // The cycle seen here is the first pressed cycle, so counting starts at 1.
                    cnt_d   = CW'(1);
                    bits_d  = '0;
                    err_d   = 1'b0;
                    state_d = D_PRESS;
                end
            end
            E_MARK: begin
                if (cnt_q == (bits_q[0] ? C3M : C1M)) begin
                    cnt_d   = '0;
                    state_d = (idx_q + 3'd1 < len_q) ? E_GAP : E_LGAP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            E_GAP: begin
                if (cnt_q == C1M) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + 3'd1;
                    bits_d  = bits_q >> 1;
                    state_d = E_MARK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            E_LGAP: begin
                if (cnt_q == C3M) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            D_PRESS: begin
                if (key_s) begin
                    if (cnt_q >= C7M) begin
                        cnt_d = C7;
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    // A saturated press is already an error and is not appended.
                    if (cnt_q != C7) begin
                        if (idx_q == LMAX) begin
                            err_d = 1'b1;
                        end else begin
                            bits_d = bits_q | (MAX_LEN'(cnt_q >= C2) << idx_q);
                            idx_d  = idx_q + 3'd1;
                        end
                    end
                    cnt_d   = CW'(1);
                    state_d = D_GAP;
                end
            end
            D_GAP: begin
                if (key_s) begin
                    cnt_d   = CW'(1);
                    state_d = D_PRESS;
                end else if (cnt_q == C3M) begin
                    if (!err_q && idx_q <= LMAX) begin
                        dv_d    = 1'b1;
                        dlen_d  = idx_q;
                        dbits_d = bits_q;
                    end else begin
                        de_d = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            bits_q  <= '0;
            err_q   <= 1'b0;
            dv_q    <= 1'b0;
            de_q    <= 1'b0;
            dlen_q  <= '0;
            dbits_q <= '0;
            ks1_q   <= 1'b0;
            ks2_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            bits_q  <= bits_d;
            err_q   <= err_d;
            dv_q    <= dv_d;
            de_q    <= de_d;
            dlen_q  <= dlen_d;
            dbits_q <= dbits_d;
            ks1_q   <= key;
            ks2_q   <= ks1_q;
        end
    end

    assign tone      = (state_q == E_MARK);
    assign busy      = (state_q != IDLE);
    assign enc_ready = (state_q == IDLE) && mode;
    assign dec_valid = dv_q;
    assign dec_err   = de_q;
    assign dec_len   = dlen_q;
    assign dec_bits  = dbits_q;
endmodule

// File: tb/tb_morse_codec.sv
// Randomised bench for morse_codec: the stimulus pushes expected tone runs / decode results, and a negedge monitor pops and compares them.
module tb_morse_codec;
    localparam int UNIT    = 4;
    localparam int MAX_LEN = 5;

    logic               clk = 1'b0;
    logic               rst, mode, enc_valid, key;
    logic [2:0]         enc_len;
    logic [MAX_LEN-1:0] enc_bits;
    logic               enc_ready, tone, dec_valid, dec_err, busy;
    logic [2:0]         dec_len;
    logic [MAX_LEN-1:0] dec_bits;

    always #5 clk = ~clk;

    morse_codec #(.UNIT(UNIT), .MAX_LEN(MAX_LEN), .DB_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .mode(mode), .enc_valid(enc_valid), .enc_ready(enc_ready),
        .enc_len(enc_len), .enc_bits(enc_bits), .tone(tone), .key(key),
        .dec_valid(dec_valid), .dec_len(dec_len), .dec_bits(dec_bits),
        .dec_err(dec_err), .busy(busy)
    );

    typedef struct {bit err; int len; int bits;} dec_ev_t;

    int      n_chk = 0;
    int      n_pass = 0;
    int      seg_q[$];
    dec_ev_t dec_q[$];
    int      last_len = 0;
    int      last_bits = 0;
    bit      mon_rst = 1'b1;
    int      dec_seen = 0;
    int      pd[7];
    int      pg[7];

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic pop_seg(string name, int act);
        chk({name, "_expected"}, int'(seg_q.size() > 0), 1);
        if (seg_q.size() > 0) chk(name, act, seg_q.pop_front());
    endtask

    // Monitor: measures tone run lengths and checks decoder pulses.
    int run = 0;
    bit prev_tone = 1'b0, prev_busy = 1'b0, in_char = 1'b0;
    always @(negedge clk) begin
        if (mon_rst) begin
            in_char   = 1'b0;
            run       = 0;
            prev_tone = tone;
            prev_busy = busy;
        end else begin
            if (tone !== prev_tone) begin
                if (prev_tone) pop_seg("mark_len", run);
                else if (in_char) pop_seg("space_len", run);
                else in_char = 1'b1;
                run = 1;
            end else begin
                run++;
            end
            if (prev_busy && !busy && in_char) begin
                pop_seg("final_space_len", run - 1);
                chk("enc_ready_on_idle", enc_ready, 1);
                in_char = 1'b0;
            end
            prev_tone = tone;
            prev_busy = busy;
        end
        if (!rst && (dec_valid === 1'b1 || dec_err === 1'b1)) begin
            dec_ev_t e;
            dec_seen++;
            chk("dec_single_kind", int'(dec_valid && dec_err), 0);
            chk("dec_expected", int'(dec_q.size() > 0), 1);
            if (dec_q.size() > 0) begin
                e = dec_q.pop_front();
                chk("dec_err_flag", dec_err, e.err);
                chk("dec_len", dec_len, e.len);
                chk("dec_bits", int'(dec_bits), e.bits);
            end
        end
    end

    // Expected waveform: each element is a mark (1 or 3 units) followed by a 1-unit space, the last by 3 units.
    task automatic do_encode(int len, int bits, bit toggle);
        int t;
        for (int i = 0; i < len; i++) begin
            seg_q.push_back(((bits >> i) & 1) != 0 ? 3*UNIT : UNIT);
            seg_q.push_back(i < len - 1 ? UNIT : 3*UNIT);
        end
        @(negedge clk);
        mode = 1'b1; enc_len = 3'(len); enc_bits = MAX_LEN'(bits); enc_valid = 1'b1;
        @(negedge clk);
        enc_valid = 1'b0;
        if (toggle) begin
            repeat (5) @(negedge clk);
            mode = 1'b0;
            repeat (2) @(negedge clk);
            mode = 1'b1;
        end
        t = 0;
        while (busy && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("enc_complete", busy, 0);
        @(negedge clk);
    endtask

    // Expected result: presses of 2+ units are dashes, 7+ units or a 6th element make the character an error.
    task automatic do_decode(int n);
        bit err = 1'b0;
        int len = 0, bits = 0;
        dec_ev_t e;
        for (int i = 0; i < n; i++) begin
            if (pd[i] >= 7*UNIT) err = 1'b1;
            else if (len == MAX_LEN) err = 1'b1;
            else begin
                if (pd[i] >= 2*UNIT) bits |= (1 << len);
                len++;
            end
        end
        if (err) begin
            e.err = 1'b1; e.len = last_len; e.bits = last_bits;
        end else begin
            e.err = 1'b0; e.len = len; e.bits = bits;
            last_len = len; last_bits = bits;
        end
        dec_q.push_back(e);
        @(negedge clk);
        mode = 1'b0;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            key = 1'b1;
            repeat (pd[i]) @(negedge clk);
            key = 1'b0;
            repeat (i < n - 1 ? pg[i] : 20) @(negedge clk);
        end
    endtask

    initial begin
        int seen0;
        rst = 1'b1; mode = 1'b1; enc_valid = 1'b0; enc_len = '0; enc_bits = '0; key = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tone", tone, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dec_valid", dec_valid, 0);
        chk("rst_dec_err", dec_err, 0);
        chk("rst_dec_len", dec_len, 0);
        chk("rst_dec_bits", int'(dec_bits), 0);
        chk("rst_enc_ready_mode1", enc_ready, 1);
        mode = 1'b0;
        #1 chk("rst_enc_ready_mode0", enc_ready, 0);
        @(negedge clk);
        mode = 1'b1; rst = 1'b0; mon_rst = 1'b0;
        @(negedge clk);
        chk("post_rst_enc_ready", enc_ready, 1);

        // Directed cases.
        do_encode(3, 5'b00010, 1'b0);
        pd[0] = 4; pd[1] = 12; pg[0] = 4;
        do_decode(2);
        for (int i = 0; i < 6; i++) begin pd[i] = 4; pg[i] = 4; end
        do_decode(6);
        pd[0] = 40;
        do_decode(1);
        do_encode(2, 0, 1'b1);

        // Ignored requests with bad length.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            mode = 1'b1; enc_len = (i == 0) ? 3'd0 : 3'd6; enc_bits = '1; enc_valid = 1'b1;
            @(negedge clk);
            enc_valid = 1'b0;
            chk("bad_len_busy", busy, 0);
            chk("bad_len_enc_ready", enc_ready, 1);
            @(negedge clk);
            chk("bad_len_tone", tone, 0);
        end

        // Reset in the middle of a dash, then a clean single-element encode.
        mon_rst = 1'b1;
        @(negedge clk);
        mode = 1'b1; enc_len = 3'd1; enc_bits = 5'b00001; enc_valid = 1'b1;
        @(negedge clk);
        enc_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("dash_tone_before_rst", tone, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_dash_tone", tone, 0);
        chk("rst_mid_dash_busy", busy, 0);
        chk("rst_mid_dash_dec_len", dec_len, 0);
        last_len = 0; last_bits = 0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        mon_rst = 1'b0;
        @(negedge clk);
        do_encode(1, 5'b00001, 1'b0);

        // Reset in the middle of a decoded character: no result pulse.
        seen0 = dec_seen;
        mode = 1'b0;
        @(negedge clk);
        key = 1'b1; repeat (4) @(negedge clk);
        key = 1'b0; repeat (3) @(negedge clk);
        rst = 1'b1; @(negedge clk);
        rst = 1'b0; repeat (25) @(negedge clk);
        chk("rst_mid_decode_no_pulse", dec_seen, seen0);

        // Random traffic.
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(1, 0) == 1) begin
                do_encode(int'($urandom_range(MAX_LEN, 1)), int'($urandom_range(31, 0)), 1'b0);
            end else begin
                int n;
                n = int'($urandom_range(6, 1));
                for (int i = 0; i < n; i++) begin
                    case ($urandom_range(9, 0))
                        0:       pd[i] = 40;
                        1, 2, 3: pd[i] = int'($urandom_range(24, 10));
                        default: pd[i] = int'($urandom_range(6, 2));
                    endcase
                    pg[i] = int'($urandom_range(9, 2));
                end
                do_decode(n);
            end
        end

        repeat (5) @(negedge clk);
        chk("seg_leftover", seg_q.size(), 0);
        chk("dec_leftover", dec_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
